// File: rtl/alu_pkg.sv
// Shared ALU/branch definitions: op-codes, resolver state encoding and op-class helpers.
// The comparator and the branch resolver both import this package so they agree on op-codes.
package alu_pkg;

  // Operation codes carried on Instruction_to_ALU.
  localparam logic [4:0] OP_BEQ  = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd1;
  localparam logic [4:0] OP_BLT  = 5'd2;
  localparam logic [4:0] OP_BGE  = 5'd3;
  localparam logic [4:0] OP_BLTU = 5'd4;
  localparam logic [4:0] OP_BGEU = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;

  // Branch resolver states, kept as plain constants so older tools and testers can share them.
  typedef logic [1:0] br_state_t;
  localparam br_state_t ST_IDLE     = 2'd0;
  localparam br_state_t ST_WAIT_CMP = 2'd1;
  localparam br_state_t ST_RESOLVE  = 2'd2;
  localparam br_state_t ST_FLUSH    = 2'd3;

  function automatic logic op_is_branch(input logic [4:0] op);
    logic is_br;
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: is_br = 1'b1;
      default:                                          is_br = 1'b0;
    endcase
    return is_br;
  endfunction

  function automatic logic op_is_slt(input logic [4:0] op);
    return (op == OP_SLT) || (op == OP_SLTU);
  endfunction

  // Only these ops are accepted by the resolver; anything else is dropped in IDLE.
  function automatic logic op_is_supported(input logic [4:0] op);
    return op_is_branch(op) || op_is_slt(op);
  endfunction

endpackage : alu_pkg

// File: rtl/branch_resolver_if.sv
// Operand/result bundle between the issue stage, the comparator and the branch resolver.
// master drives operands and the write-back ready; slave is the resolver itself.
interface branch_resolver_if;

  logic        dat_ready;
  logic [4:0]  Instruction_to_ALU;
  logic [31:0] pc_in;
  logic [31:0] imm_in;
  logic        Comparator_con_met;
  logic        wb_ready;

  logic        busy;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_misalign;
  logic        slt_wb_valid;
  logic [31:0] slt_wb_data;
  logic        flush;

  modport master (
    output dat_ready, Instruction_to_ALU, pc_in, imm_in, Comparator_con_met, wb_ready,
    input  busy, br_valid, br_taken, br_target, br_misalign, slt_wb_valid, slt_wb_data, flush
  );

  modport slave (
    input  dat_ready, Instruction_to_ALU, pc_in, imm_in, Comparator_con_met, wb_ready,
    output busy, br_valid, br_taken, br_target, br_misalign, slt_wb_valid, slt_wb_data, flush
  );

endinterface : branch_resolver_if

// File: rtl/branch_resolver.sv
// Resolves branches and SLT results one cycle after the comparator answers, then
// holds the result for the write-back handshake and squashes younger work on taken branches.
module branch_resolver
  import alu_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2  // legal range 1..15
) (
  input  logic              soc_clk,
  input  logic              reset,
  branch_resolver_if.slave  br_if
);

  br_state_t   state;
  logic [4:0]  op_q;
  logic [31:0] pc_q;
  logic [31:0] imm_q;
  logic [3:0]  flush_cnt;

  logic        br_valid_q;
  logic        br_taken_q;
  logic [31:0] br_target_q;
  logic        br_misalign_q;
  logic        slt_valid_q;
  logic [31:0] slt_data_q;
  logic        flush_q;

  logic [31:0] taken_target;
  logic [31:0] seq_target;
  logic        con_met;
  logic        take_flush;

  // Both candidate targets wrap modulo 2^32; there is deliberately no carry out.
  assign taken_target = pc_q + imm_q;
  assign seq_target   = pc_q + 32'd4;
  assign con_met      = br_if.Comparator_con_met;
  assign take_flush   = br_valid_q & br_taken_q & ~br_misalign_q;

  // NOTE: every register here, captured operands included, sits on the async reset so an
  // aborted operation leaves no stale target or flush behind when reset releases.
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      op_q          <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      flush_cnt     <= '0;
      br_valid_q    <= 1'b0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
      br_misalign_q <= 1'b0;
      slt_valid_q   <= 1'b0;
      slt_data_q    <= '0;
      flush_q       <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every branch reads pre-edge values.
      case (state)
        ST_IDLE: begin
          if (br_if.dat_ready && op_is_supported(br_if.Instruction_to_ALU)) begin
            op_q  <= br_if.Instruction_to_ALU;
            pc_q  <= br_if.pc_in;
            imm_q <= br_if.imm_in;
            state <= ST_WAIT_CMP;
          end
        end

        ST_WAIT_CMP: begin
          if (op_is_branch(op_q)) begin
            br_valid_q    <= 1'b1;
            br_taken_q    <= con_met;
            br_target_q   <= con_met ? taken_target : seq_target;
            br_misalign_q <= con_met & (|taken_target[1:0]);
            slt_valid_q   <= 1'b0;
            slt_data_q    <= '0;
          end else begin
            br_valid_q    <= 1'b0;
            br_taken_q    <= 1'b0;
            br_target_q   <= '0;
            br_misalign_q <= 1'b0;
            slt_valid_q   <= 1'b1;
            slt_data_q    <= {31'b0, con_met};
          end
          state <= ST_RESOLVE;
        end

        ST_RESOLVE: begin
          // Results stay frozen until downstream takes them.
          if (br_if.wb_ready) begin
            br_valid_q    <= 1'b0;
            br_taken_q    <= 1'b0;
            br_target_q   <= '0;
            br_misalign_q <= 1'b0;
            slt_valid_q   <= 1'b0;
            slt_data_q    <= '0;
            if (take_flush) begin
              flush_q   <= 1'b1;
              flush_cnt <= 4'(FLUSH_CYCLES - 1);
              state     <= ST_FLUSH;
            end else begin
              state     <= ST_IDLE;
            end
          end
        end

        ST_FLUSH: begin
          // flush rose on the handshake edge, so counting down from N-1 yields N high cycles.
          if (flush_cnt == 4'd0) begin
            flush_q <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign br_if.busy         = (state != ST_IDLE);
  assign br_if.br_valid     = br_valid_q;
  assign br_if.br_taken     = br_taken_q;
  assign br_if.br_target    = br_target_q;
  assign br_if.br_misalign  = br_misalign_q;
  assign br_if.slt_wb_valid = slt_valid_q;
  assign br_if.slt_wb_data  = slt_data_q;
  assign br_if.flush        = flush_q;

endmodule : branch_resolver

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed corner cases plus randomized transactions, with expected
// per-cycle outputs derived from a transaction timeline and checked on every falling edge.
module tb_branch_resolver;
  import alu_pkg::*;

  localparam int unsigned FLUSH_N = 2;

  logic soc_clk;
  logic reset;

  branch_resolver_if br_if ();

  branch_resolver #(.FLUSH_CYCLES(FLUSH_N)) dut (
    .soc_clk (soc_clk),
    .reset   (reset),
    .br_if   (br_if.slave)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Expected outputs for the current cycle.
  logic        exp_busy      = 1'b0;
  logic        exp_br_valid  = 1'b0;
  logic        exp_taken     = 1'b0;
  logic [31:0] exp_target    = '0;
  logic        exp_mis       = 1'b0;
  logic        exp_slt_valid = 1'b0;
  logic [31:0] exp_slt_data  = '0;
  logic        exp_flush     = 1'b0;
  logic        chk_all       = 1'b1;  // every output must read zero (reset aftermath)

  logic [4:0] legal_ops [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge soc_clk);
    #1;
  endtask

  function automatic logic [4:0] pick_legal();
    return legal_ops[$urandom_range(0, 7)];
  endfunction

  function automatic logic [4:0] pick_illegal();
    logic [4:0] o;
    do o = 5'($urandom_range(0, 31)); while (o <= 5'd5 || o == 5'd9 || o == 5'd10);
    return o;
  endfunction

  task automatic set_idle_exp();
    exp_busy      = 1'b0;
    exp_br_valid  = 1'b0;
    exp_slt_valid = 1'b0;
    exp_flush     = 1'b0;
  endtask

  // Random upstream activity while the block is busy; it must never be captured.
  task automatic drive_noise(input bit noise);
    br_if.dat_ready          = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    br_if.Instruction_to_ALU = pick_legal();
    br_if.pc_in              = $urandom;
    br_if.imm_in             = $urandom;
  endtask

  // Compare process: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge soc_clk) begin
    check("busy",         32'(br_if.busy),         32'(exp_busy));
    check("br_valid",     32'(br_if.br_valid),     32'(exp_br_valid));
    check("slt_wb_valid", 32'(br_if.slt_wb_valid), 32'(exp_slt_valid));
    check("flush",        32'(br_if.flush),        32'(exp_flush));
    if (chk_all) begin
      check("br_taken_zero",  32'(br_if.br_taken),    32'd0);
      check("br_target_zero", br_if.br_target,        32'd0);
      check("misalign_zero",  32'(br_if.br_misalign), 32'd0);
      check("slt_data_zero",  br_if.slt_wb_data,      32'd0);
    end
    if (exp_br_valid) begin
      check("br_taken",    32'(br_if.br_taken),    32'(exp_taken));
      check("br_target",   br_if.br_target,        exp_target);
      check("br_misalign", 32'(br_if.br_misalign), 32'(exp_mis));
    end
    if (exp_slt_valid) check("slt_wb_data", br_if.slt_wb_data, exp_slt_data);
  end

  // One transaction from dat_ready to IDLE. abort_after > 0 returns after that many edges
  // so reset can be applied mid-operation.
  task automatic run_txn(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic con, input int wb_delay, input bit noise,
                         input int abort_after, output int flush_seen,
                         output logic res_taken, output logic [31:0] res_target,
                         output logic res_mis, output logic [31:0] res_slt);
    bit          is_br;
    logic [31:0] sum;
    int          edges;
    is_br      = (op <= 5'd5);
    sum        = pc + imm;
    flush_seen = 0;
    edges      = 0;
    res_taken  = 1'b0;
    res_target = '0;
    res_mis    = 1'b0;
    res_slt    = '0;
    chk_all    = 1'b0;

    br_if.dat_ready          = 1'b1;
    br_if.Instruction_to_ALU = op;
    br_if.pc_in              = pc;
    br_if.imm_in             = imm;
    br_if.Comparator_con_met = 1'($urandom_range(0, 1));
    br_if.wb_ready           = 1'($urandom_range(0, 1));
    step(); edges++;
    exp_busy = 1'b1;
    if (edges == abort_after) return;

    drive_noise(noise);
    br_if.Comparator_con_met = con;
    step(); edges++;
    exp_br_valid  = is_br;
    exp_taken     = con;
    exp_target    = con ? sum : pc + 32'd4;
    exp_mis       = con && (sum[1:0] != 2'b00);
    exp_slt_valid = !is_br;
    exp_slt_data  = {31'b0, con};
    res_taken     = br_if.br_taken;
    res_target    = br_if.br_target;
    res_mis       = br_if.br_misalign;
    res_slt       = br_if.slt_wb_data;
    if (edges == abort_after) return;

    br_if.Comparator_con_met = 1'($urandom_range(0, 1));
    for (int d = 0; d < wb_delay; d++) begin
      br_if.wb_ready = 1'b0;
      drive_noise(noise);
      step(); edges++;
      if (edges == abort_after) return;
    end
    br_if.wb_ready = 1'b1;
    drive_noise(noise);
    step(); edges++;
    br_if.wb_ready = 1'b0;
    exp_br_valid   = 1'b0;
    exp_slt_valid  = 1'b0;
    if (is_br && con && sum[1:0] == 2'b00) begin
      exp_flush = 1'b1;
      flush_seen += int'(br_if.flush);
      if (edges == abort_after) return;
      for (int k = 1; k < int'(FLUSH_N); k++) begin
        drive_noise(noise);
        step();
        flush_seen += int'(br_if.flush);
      end
      drive_noise(noise);
      step();
    end
    set_idle_exp();
    flush_seen += int'(br_if.flush);
    br_if.dat_ready = 1'b0;
  endtask

  // Asserts reset between edges and expects every output to drop without waiting for a clock.
  task automatic apply_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_busy"},     32'(br_if.busy),         32'd0);
    check({tag, "_br_valid"}, 32'(br_if.br_valid),     32'd0);
    check({tag, "_target"},   br_if.br_target,         32'd0);
    check({tag, "_slt"},      32'(br_if.slt_wb_valid), 32'd0);
    check({tag, "_flush"},    32'(br_if.flush),        32'd0);
    set_idle_exp();
    chk_all                  = 1'b1;
    br_if.dat_ready          = 1'b0;
    br_if.wb_ready           = 1'b0;
    step();
    #2;
    reset = 1'b1;
  endtask

  int          fs;
  logic        r_taken, r_mis;
  logic [31:0] r_target, r_slt;

  initial begin
    br_if.dat_ready          = 1'b0;
    br_if.Instruction_to_ALU = '0;
    br_if.pc_in              = '0;
    br_if.imm_in             = '0;
    br_if.Comparator_con_met = 1'b0;
    br_if.wb_ready           = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    step();
    step();
    #2 reset = 1'b1;

    // Taken, aligned BEQ: result two cycles after dat_ready, then a two-cycle flush.
    run_txn(OP_BEQ, 32'h100, 32'h20, 1'b1, 0, 1'b0, -1, fs, r_taken, r_target, r_mis, r_slt);
    check("beq_taken",  32'(r_taken), 32'd1);
    check("beq_target", r_target,     32'h120);
    check("beq_flush_cycles", 32'(fs), 32'd2);

    // Not-taken BLTU falls through to pc+4 with no flush.
    run_txn(OP_BLTU, 32'h200, 32'h40, 1'b0, 1, 1'b1, -1, fs, r_taken, r_target, r_mis, r_slt);
    check("bltu_taken",  32'(r_taken), 32'd0);
    check("bltu_target", r_target,     32'h204);
    check("bltu_flush_cycles", 32'(fs), 32'd0);

    // Target addition wraps around 2^32.
    run_txn(OP_BNE, 32'hFFFF_FFF0, 32'h14, 1'b1, 0, 1'b0, -1, fs, r_taken, r_target, r_mis, r_slt);
    check("bne_wrap_target", r_target, 32'h0000_0004);

    // Misaligned taken target: flagged, and no flush.
    run_txn(OP_BGE, 32'h100, 32'h22, 1'b1, 2, 1'b0, -1, fs, r_taken, r_target, r_mis, r_slt);
    check("bge_misalign", 32'(r_mis), 32'd1);
    check("bge_flush_cycles", 32'(fs), 32'd0);

    // SLTU held through three cycles of back-pressure, with upstream noise while busy.
    run_txn(OP_SLTU, 32'h300, 32'h8, 1'b1, 3, 1'b1, -1, fs, r_taken, r_target, r_mis, r_slt);
    check("sltu_data", r_slt, 32'h1);

    // Unsupported op in IDLE is dropped.
    br_if.dat_ready          = 1'b1;
    br_if.Instruction_to_ALU = 5'd7;
    step();
    br_if.dat_ready = 1'b0;
    check("illegal_op_idle", 32'(br_if.busy), 32'd0);

    // Reset during FLUSH, then during RESOLVE, each followed by a clean BEQ.
    run_txn(OP_BEQ, 32'h400, 32'h10, 1'b1, 0, 1'b0, 3, fs, r_taken, r_target, r_mis, r_slt);
    apply_reset("rst_flush");
    run_txn(OP_BEQ, 32'h100, 32'h20, 1'b1, 0, 1'b0, -1, fs, r_taken, r_target, r_mis, r_slt);
    check("post_rst1_target", r_target, 32'h120);
    check("post_rst1_flush",  32'(fs),  32'd2);

    run_txn(OP_BLT, 32'h500, 32'h30, 1'b1, 5, 1'b0, 2, fs, r_taken, r_target, r_mis, r_slt);
    apply_reset("rst_resolve");
    run_txn(OP_BEQ, 32'h100, 32'h20, 1'b1, 0, 1'b0, -1, fs, r_taken, r_target, r_mis, r_slt);
    check("post_rst2_target", r_target, 32'h120);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] pc, imm;
      logic        con;
      if ($urandom_range(0, 3) == 0) begin
        br_if.dat_ready          = 1'b1;
        br_if.Instruction_to_ALU = pick_illegal();
        step();
        br_if.dat_ready = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) step();
      pc  = $urandom;
      imm = $urandom;
      if ($urandom_range(0, 1) == 1) pc[1:0]  = 2'b00;
      if ($urandom_range(0, 1) == 1) imm[1:0] = 2'b00;
      con = 1'($urandom_range(0, 1));
      run_txn(pick_legal(), pc, imm, con, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1,
              fs, r_taken, r_target, r_mis, r_slt);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before t=1000000");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_branch_resolver
